// File: rtl/gray_ptr_ctrl_if.sv
`timescale 1ns/1ps
// Bus between one FIFO side's pointer controller and the logic around it:
// request/clear and synchronised remote pointer in, address/pointer/status out.
interface gray_ptr_if #(
  parameter int ADDR_WIDTH = 4
);
  localparam int N = ADDR_WIDTH + 1;

  logic                  inc_i;
  logic                  clr_i;
  logic [N-1:0]          remote_gray_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [N-1:0]          ptr_gray_o;
  logic                  flag_o;
  logic                  almost_o;
  logic [N-1:0]          level_o;
  logic                  err_o;

  modport master (
    output inc_i, clr_i, remote_gray_i,
    input  addr_o, ptr_gray_o, flag_o, almost_o, level_o, err_o
  );

  modport slave (
    input  inc_i, clr_i, remote_gray_i,
    output addr_o, ptr_gray_o, flag_o, almost_o, level_o, err_o
  );
endinterface

// File: rtl/gray_ptr_ctrl.sv
`timescale 1ns/1ps
// Async-FIFO pointer controller for one side of the FIFO.
// MODE 0 is the write side (flag = full), MODE 1 the read side (flag = empty).
// Binary and Gray pointers are both registered so the Gray image leaving
// this domain changes exactly one bit per accepted increment.
module gray_ptr_ctrl #(
  parameter int DLY        = 1,
  parameter int ADDR_WIDTH = 4,
  parameter int MODE       = 0,
  parameter int ALMOST_TH  = 2
) (
  input logic       clk_i,
  input logic       rst_n_i,
  gray_ptr_if.slave bus
);
  localparam int N     = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic         RST_FLAG  = (MODE == 1);
  localparam logic [N-1:0] FULL_TH   = N'(DEPTH - ALMOST_TH);
  localparam logic [N-1:0] EMPTY_TH  = N'(ALMOST_TH);

  // DLY only shapes simulation timing elsewhere; here it is just sanity-checked
  // together with the structural parameters at elaboration.
  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 16 || ALMOST_TH < 1 ||
      ALMOST_TH > DEPTH - 1 || MODE < 0 || MODE > 1 || DLY < 0) begin : g_bad_param
    $error("gray_ptr_ctrl: illegal parameter combination");
  end

  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] gray_q, gray_d;
  logic [N-1:0] level_q, level_d;
  logic         flag_q, flag_d;
  logic         almost_q, almost_d;
  logic         err_q, err_d;
  logic         inc_ok;
  logic [N-1:0] remote_bin;

  // Gray-to-binary of the remote pointer: each binary bit is the XOR of all
  // Gray bits from the MSB down to that position.
  always_comb begin
    remote_bin = '0;
    for (int i = 0; i < N; i++) begin
      remote_bin[i] = ^(bus.remote_gray_i >> i);
    end
  end

  // Next-state: pointer advance, Gray image, fill level, flag, almost and sticky error.
  // The write-side full test compares against the remote Gray pointer with its top
  // two bits inverted, which is the Gray image of remote_bin + DEPTH.
  always_comb begin
    inc_ok   = bus.inc_i & ~flag_q & ~bus.clr_i;
    bin_d    = bus.clr_i ? '0 : bin_q + {{(N-1){1'b0}}, inc_ok};
    gray_d   = bin_d ^ (bin_d >> 1);
    level_d  = '0;
    flag_d   = 1'b0;
    almost_d = 1'b0;
    if (MODE == 0) begin
      level_d  = bin_d - remote_bin;
      flag_d   = (gray_d == {~bus.remote_gray_i[N-1:N-2], bus.remote_gray_i[N-3:0]});
      almost_d = (level_d >= FULL_TH);
    end else begin
      level_d  = remote_bin - bin_d;
      flag_d   = (gray_d == bus.remote_gray_i);
      almost_d = (level_d <= EMPTY_TH);
    end
    err_d = bus.clr_i ? 1'b0 : (err_q | (bus.inc_i & flag_q));
  end

  // State registers; reset puts the read side into the empty condition.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      flag_q   <= RST_FLAG;
      almost_q <= RST_FLAG;
      err_q    <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
      err_q    <= err_d;
    end
  end

  assign bus.addr_o     = bin_q[ADDR_WIDTH-1:0];
  assign bus.ptr_gray_o = gray_q;
  assign bus.flag_o     = flag_q;
  assign bus.almost_o   = almost_q;
  assign bus.level_o    = level_q;
  assign bus.err_o      = err_q;
endmodule
